// File: rtl/data_memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_responder_pkg
// Shared definitions for the data-memory responder and its storage array:
//   - state_t     : responder FSM encoding (IDLE / WAIT / RESP)
//   - DEFAULT_*   : default depth (words) and response latency (cycles)
//   - WORD_BYTES  : bytes per 32-bit word (byte address -> word index)
//   - idx_width() : word-index width for a given depth (at least 1 bit)
// ---------------------------------------------------------------------------
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 3;
  localparam int WORD_BYTES      = 4;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_memory_responder_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit storage with a single synchronous port. On a clock edge with
// en_i=1 it either writes wdata_i (we_i=1) or registers the addressed word
// into rdata_o (we_i=0). The contents are never cleared.
// Ports:
//   clk_i    : clock
//   en_i     : port enable for this cycle
//   we_i     : 1 = write, 0 = read
//   idx_i    : word index
//   wdata_i  : write data
//   rdata_o  : registered read data (holds until the next enabled read)
// ---------------------------------------------------------------------------
module dmem_array
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage has no reset; the caller only enables the port for in-range indices.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
// Word-addressed data memory that answers MEM-stage load/store requests a
// fixed LATENCY cycles after the request cycle, with a one-cycle ack pulse,
// an error pulse on bad addresses, and a stall back to the pipeline while an
// access is in flight.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   req_i    : access request, held high by the MEM stage until ack_o
//   we_i     : 1 = store, 0 = load
//   addr_i   : byte address (must be word aligned and below DEPTH words)
//   wdata_i  : store data
//   rdata_o  : load data, valid while ack_o=1 (0 otherwise)
//   ack_o    : one-cycle completion pulse
//   err_o    : one-cycle pulse with ack_o when the address was bad
//   stall_o  : pipeline freeze while a request is pending or in flight
// ---------------------------------------------------------------------------
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int IDX_W = idx_width(DEPTH);
  // The WAIT counter runs from LATENCY-2 down to 0.
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             rd_q, rd_d;

  logic             go_resp;
  logic [31:0]      acc_addr;
  logic             acc_we;
  logic [31:0]      acc_wdata;
  logic             acc_bad;
  logic             mem_en;
  logic [31:0]      mem_rdata;

  // The access is performed on the edge entering RESP. With LATENCY==1 that
  // edge is the request edge itself, so the live inputs are used; otherwise
  // the copies latched in IDLE are used and later input changes are ignored.
  assign acc_addr  = (state_q == IDLE) ? addr_i  : addr_q;
  assign acc_we    = (state_q == IDLE) ? we_i    : we_q;
  assign acc_wdata = (state_q == IDLE) ? wdata_i : wdata_q;

  // The full upper address is compared so high bits cannot alias into range.
  assign acc_bad = (acc_addr[WORD_SHIFT-1:0] != '0) ||
                   ({{WORD_SHIFT{1'b0}}, acc_addr[31:WORD_SHIFT]} >= DEPTH_W);

  // Next-state, counter and latching logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rd_d    = rd_q;
    go_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          wdata_d = wdata_i;
          if (LATENCY == 1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // err_q / rd_q describe the response being presented in RESP.
    if (go_resp) begin
      err_d = acc_bad;
      rd_d  = !acc_we && !acc_bad;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Reset wins over an access whose RESP edge coincides with it.
  assign mem_en = go_resp && !acc_bad && !rst_i;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (mem_en),
    .we_i    (acc_we),
    .idx_i   (acc_addr[WORD_SHIFT +: IDX_W]),
    .wdata_i (acc_wdata),
    .rdata_o (mem_rdata)
  );

  assign ack_o   = (state_q == RESP);
  assign err_o   = (state_q == RESP) && err_q;
  assign rdata_o = ((state_q == RESP) && rd_q) ? mem_rdata : 32'h0;
  assign stall_o = ((state_q == IDLE) && req_i) || (state_q == WAIT);

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int DEPTH = 256;
  localparam int L     = 3;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack, err, stall;
  logic        req1, we1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ack1, err1, stall1;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .err_o(err), .stall_o(stall)
  );

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
  );

  int passes = 0;
  int total  = 0;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic checkBit(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %b, expected %b", nm, act, exp);
  endtask

  function automatic bit isBad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  // Behavioural model: a request accepted in cycle t is answered in cycle
  // t+L; the pipeline is stalled from t to t+L-1; a store lands at the edge
  // ending cycle t+L-1 unless reset is high in that cycle.
  bit          chk_en = 1'b0;
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_ack = 0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] mmem [DEPTH];
  bit          known [DEPTH];

  always @(negedge clk) begin : model
    logic exp_ack;
    int   idx;
    if (chk_en) begin
      exp_ack = m_busy && (cyc == m_ack);
      checkBit("cmp_ack", ack, exp_ack);
      checkBit("cmp_stall", stall, (!m_busy && req) || (m_busy && (cyc < m_ack)));
      if (exp_ack) begin
        checkBit("cmp_err", err, isBad(m_addr));
        if (isBad(m_addr) || m_we) begin
          checkOutput("cmp_rdata_zero", rdata, 32'h0);
        end else begin
          idx = int'(m_addr[31:2]);
          if (known[idx]) checkOutput("cmp_rdata", rdata, mmem[idx]);
        end
      end else begin
        checkBit("cmp_err_idle", err, 1'b0);
      end
    end
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (cyc == m_ack) m_busy = 1'b0;
    end else if (req) begin
      m_busy  = 1'b1;
      m_ack   = cyc + L;
      m_we    = we;
      m_addr  = addr;
      m_wdata = wdata;
    end
    if (!rst && m_busy && (cyc == m_ack - 1) && m_we && !isBad(m_addr)) begin
      idx = int'(m_addr[31:2]);
      mmem[idx]  = m_wdata;
      known[idx] = 1'b1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  // Directed transaction with hand-computed per-cycle expectations.
  task automatic directedTxn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic exp_err, input logic [31:0] exp_rd, input bit scramble);
    applyStimulus(1'b1, w, a, d);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      checkBit({nm, "_stall"}, stall, k < L);
      checkBit({nm, "_ack"}, ack, k == L);
      if (k == L) begin
        checkBit({nm, "_err"}, err, exp_err);
        checkOutput({nm, "_rdata"}, rdata, exp_rd);
      end
      tick();
      if (scramble && k < L) applyStimulus(1'b1, ~w, a + 32'h10, ~d);
    end
    req = 1'b0;
  endtask

  task automatic randTxn(input logic w, input logic [31:0] a, input logic [31:0] d, input bit scr);
    bit seen;
    seen = 1'b0;
    applyStimulus(1'b1, w, a, d);
    for (int k = 0; k < 4 * L + 4 && !seen; k++) begin
      @(negedge clk);
      if (ack === 1'b1) seen = 1'b1;
      tick();
      if (!seen && scr) applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    checkBit("ack_seen", seen, 1'b1);
    req = 1'b0;
  endtask

  task automatic resetTxn(input logic w, input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, w, a, d);
    repeat ($urandom_range(0, L)) tick();
    rst = 1'b1;
    req = 1'($urandom_range(0, 1));
    tick();
    rst = 1'b0;
    req = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int          sel;
    int          n_rst;
    logic [31:0] a;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    tick();
    chk_en = 1'b1;

    // Reset state.
    @(negedge clk);
    checkBit("rst_ack", ack, 1'b0);
    checkBit("rst_err", err, 1'b0);
    checkBit("rst_stall", stall, 1'b0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkBit("rst_ack1", ack1, 1'b0);
    checkBit("rst_stall1", stall1, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkBit("idle_stall", stall, 1'b0);
    tick();

    // Directed scenarios.
    directedTxn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    directedTxn("ld10", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    directedTxn("mis13", 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b0);
    directedTxn("st0", 1'b1, 32'h0, 32'hCAFE0000, 1'b0, 32'h0, 1'b0);
    directedTxn("st400", 1'b1, 32'h400, 32'h11111111, 1'b1, 32'h0, 1'b0);
    directedTxn("ld0", 1'b0, 32'h0, 32'h0, 1'b0, 32'hCAFE0000, 1'b0);
    directedTxn("iso", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    directedTxn("st8", 1'b1, 32'h8, 32'h1, 1'b0, 32'h0, 1'b0);

    // Reset in cycle 2 of a store to 0x8.
    applyStimulus(1'b1, 1'b1, 32'h8, 32'h55);
    tick();
    tick();
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    checkBit("rstmid_ack_c2", ack, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkBit("rstmid_ack_c3", ack, 1'b0);
    checkBit("rstmid_stall_c3", stall, 1'b0);
    tick();
    directedTxn("ld8", 1'b0, 32'h8, 32'h0, 1'b0, 32'h1, 1'b0);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) randTxn(1'b1, 32'(i) << 2, $urandom, 1'b0);

    // Randomised traffic with bad addresses, input churn and resets.
    n_rst = 0;
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 8) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel < 10) a = 32'(DEPTH) << 2;
      else if (sel < 16) a = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
      else if (sel < 18) a = 32'(DEPTH - 1) << 2;
      else a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if ($urandom_range(0, 99) < 10) begin
        resetTxn(1'($urandom_range(0, 1)), a, $urandom);
        n_rst++;
      end else begin
        randTxn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2) == 0);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("[TB] random phase done, %0d resets injected", n_rst);

    // LATENCY=1 instance.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0; wdata1 = 32'h12345678;
    @(negedge clk);
    checkBit("l1_st_stall_c0", stall1, 1'b1);
    checkBit("l1_st_ack_c0", ack1, 1'b0);
    tick();
    @(negedge clk);
    checkBit("l1_st_ack_c1", ack1, 1'b1);
    checkBit("l1_st_stall_c1", stall1, 1'b0);
    checkBit("l1_st_err_c1", err1, 1'b0);
    tick();
    we1 = 1'b0;
    @(negedge clk);
    checkBit("l1_ld_stall_c0", stall1, 1'b1);
    checkBit("l1_ld_ack_c0", ack1, 1'b0);
    tick();
    @(negedge clk);
    checkBit("l1_ld_ack_c1", ack1, 1'b1);
    checkBit("l1_ld_stall_c1", stall1, 1'b0);
    checkOutput("l1_ld_rdata", rdata1, 32'h12345678);
    tick();
    addr1 = 32'h2;
    @(negedge clk);
    checkBit("l1_mis_ack_c0", ack1, 1'b0);
    tick();
    @(negedge clk);
    checkBit("l1_mis_ack_c1", ack1, 1'b1);
    checkBit("l1_mis_err_c1", err1, 1'b1);
    checkOutput("l1_mis_rdata", rdata1, 32'h0);
    tick();
    req1 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Word-addressed data-memory responder. It serves the load/store requests that the pipeline's MEM stage initiates.
- It answers each request after a fixed, parameterised latency using a req/ack handshake.
- While an access is in flight it drives a stall back to the pipeline.
- It replaces the zero-latency memory model and lets the pipeline be exercised against realistic memory timing.

Parameters:
- DEPTH, 256: number of 32-bit words; legal word index 0..DEPTH-1.
- LATENCY, 3: cycles from the request cycle to the ack cycle; must be >=1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  1  access request from MEM stage; held high until ack_o is seen
- we_i  in  1  1 = store (sw), 0 = load (lw)
- addr_i  in  32  byte address
- wdata_i  in  32  store data
- rdata_o  out  32  load data, valid while ack_o=1
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse coincident with ack_o on a bad address
- stall_o  out  1  freeze request to the pipeline (IF/ID/EX/MEM hold)

Behaviour:
- Reset values: FSM=IDLE, counter=0, rdata_o=0, ack_o=0, err_o=0, stall_o=0. The memory array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req_i=1, latch addr_i, we_i and wdata_i at the clock edge.
  - If LATENCY==1, go to RESP; otherwise go to WAIT with cnt=LATENCY-2.
- WAIT: if cnt==0, go to RESP; otherwise decrement cnt. Changes on addr_i, we_i, wdata_i and req_i are ignored here.
- On the edge entering RESP:
  - Load with a good address: rdata_o <= mem[addr[31:2]].
  - Store with a good address: mem[addr[31:2]] <= wdata and rdata_o <= 0.
  - Bad address: no write, rdata_o <= 0, err_o <= 1.
- RESP: ack_o=1 for exactly this cycle, then always return to IDLE. A req_i still high in the RESP cycle is not a new request.
- ack_o and err_o are registered (decoded from state/flag), so there is no combinational path from any input.
- stall_o is combinational: (state==IDLE && req_i) || state==WAIT. It is 0 in RESP, so the MEM/WB buffer captures rdata_o on the RESP edge.
- Timing, with the request cycle numbered 0: ack_o is high in cycle LATENCY. The minimum spacing between accepted requests is LATENCY+1 cycles, because IDLE always intervenes.
- Bad address means either of:
  - addr_i[1:0] != 0 (misaligned);
  - addr_i[31:2] >= DEPTH (out of range).
- Address index width is clog2(DEPTH). The upper address bits are compared in full, never truncated.
- Reset mid-operation (WAIT or RESP):
  - FSM returns to IDLE and ack_o, err_o, stall_o go to 0 on the next cycle.
  - A pending store that has not yet reached the RESP edge is dropped.
  - A store whose RESP edge coincides with rst_i is also dropped, because reset has priority.
- Reset and req_i high in the same cycle: the request is not accepted. After reset, stall_o follows req_i combinationally from IDLE.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10).
  - Default DEPTH and LATENCY constants.
  - Word-size constant (4 bytes).
- One natural sub-module: dmem_array.
  - DEPTH x 32 storage with a single synchronous port: we, index, wdata, rdata registered.
  - Instanced once; the responder owns the FSM, counter, latching and error logic.

Test Plan:
- Reset then idle (LATENCY=3): all outputs are 0; stall_o=0 while req_i=0.
- Store then load (LATENCY=3):
  - Store, addr=0x10, wdata=0xDEADBEEF, req at cycle 0 → stall_o=1 in cycles 0-2, ack_o=1 in cycle 3 only, err_o=0.
  - Load from 0x10 issued in cycle 4 → ack_o in cycle 7 with rdata_o=0xDEADBEEF.
- LATENCY=1 build: load 0x0 after preloading 0x12345678 → ack_o in cycle 1, stall_o high only in cycle 0.
- Bad addresses:
  - Load 0x13 (misaligned) → err_o=1 and ack_o=1 in cycle 3, rdata_o=0.
  - Store to 0x400 (index 256 >= DEPTH) → err_o=1, and a following load of 0x0 still returns its prior value.
- Input isolation: change addr_i 0x10→0x20 and we_i during WAIT → the response uses the latched 0x10 read.
- Reset mid-access:
  - Assert rst_i in cycle 2 of a store to 0x8 (old value 0x1) → no ack_o, FSM back to IDLE.
  - A subsequent load of 0x8 returns 0x1.
